// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: enables the oscillator, lets it settle, then counts
// synchronized rising edges of osc_out over a gate window of clk cycles.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | oscillator off, waiting for req
// SETTLE  | oscillator on, edges ignored for SETTLE_CYCLES cycles
// MEASURE | gate window open for G cycles, rising edges counted
// DONE    | result held with valid until ack; may restart directly
module ro_freq_meter #(
  parameter int CNT_W         = 16,
  parameter int GATE_W        = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int SYNC_STAGES   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              continuous,
  input  logic              osc_out,
  input  logic              ack,
  output logic              ro_start,
  output logic              busy,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              valid
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_MEASURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [SET_W-1:0]       settle_q, settle_d;
  logic [GATE_W-1:0]      gate_q, gate_d;
  logic [GATE_W-1:0]      gtmr_q, gtmr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_int_q, ovf_int_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic                   valid_q, valid_d;
  logic                   ro_start_q, ro_start_d;

  logic                   sync_out;
  logic                   rise;
  logic [GATE_W-1:0]      g_eff;
  logic                   settle_done;
  logic                   gate_done;
  logic                   ack_fire;
  logic                   cnt_full;
  logic [CNT_W-1:0]       cnt_nxt;
  logic                   ovf_nxt;

  // Edge detection and shared datapath terms
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], osc_out};
    sync_out    = sync_q[SYNC_STAGES-1];
    prev_d      = sync_out;
    rise        = sync_out & ~prev_q;
    g_eff       = (gate_len == '0) ? GATE_W'(1) : gate_len;
    settle_done = (settle_q == '0);
    gate_done   = (gtmr_q == '0);
    ack_fire    = valid_q & ack;
    cnt_full    = &cnt_q;
    cnt_nxt     = (rise && !cnt_full) ? cnt_q + CNT_W'(1) : cnt_q;
    ovf_nxt     = ovf_int_q | (rise & cnt_full);
  end

  // State register and all datapath flops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sync_q     <= '0;
      prev_q     <= 1'b0;
      settle_q   <= '0;
      gate_q     <= '0;
      gtmr_q     <= '0;
      cnt_q      <= '0;
      ovf_int_q  <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      ro_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      settle_q   <= settle_d;
      gate_q     <= gate_d;
      gtmr_q     <= gtmr_d;
      cnt_q      <= cnt_d;
      ovf_int_q  <= ovf_int_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
      ro_start_q <= ro_start_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_done) state_d = S_MEASURE;
      end
      S_MEASURE: begin
        if (gate_done) state_d = S_DONE;
      end
      S_DONE: begin
        if (ack_fire) begin
          if (continuous) state_d = ro_start_q ? S_MEASURE : S_SETTLE;
          else            state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    settle_d   = settle_q;
    gate_d     = gate_q;
    gtmr_d     = gtmr_q;
    cnt_d      = cnt_q;
    ovf_int_d  = ovf_int_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    valid_d    = valid_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          gate_d   = g_eff;
          settle_d = SET_W'(SETTLE_CYCLES - 1);
        end
      end
      S_SETTLE: begin
        if (settle_done) begin
          cnt_d     = '0;
          ovf_int_d = 1'b0;
          gtmr_d    = gate_q - GATE_W'(1);
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      S_MEASURE: begin
        cnt_d     = cnt_nxt;
        ovf_int_d = ovf_nxt;
        if (gate_done) begin
          // the rise seen in the last gate cycle is part of the result
          count_d    = cnt_nxt;
          overflow_d = ovf_nxt;
          valid_d    = 1'b1;
        end else begin
          gtmr_d = gtmr_q - GATE_W'(1);
        end
      end
      S_DONE: begin
        if (ack_fire) begin
          valid_d = 1'b0;
          if (continuous) begin
            gate_d = g_eff;
            if (ro_start_q) begin
              cnt_d     = '0;
              ovf_int_d = 1'b0;
              gtmr_d    = g_eff - GATE_W'(1);
            end else begin
              settle_d = SET_W'(SETTLE_CYCLES - 1);
            end
          end
        end
      end
      default: ;
    endcase
    // In DONE the oscillator stays on only while continuous mode keeps it running
    ro_start_d = (state_d == S_SETTLE) || (state_d == S_MEASURE) ||
                 ((state_d == S_DONE) && continuous && ro_start_q);
  end

  assign ro_start = ro_start_q;
  assign busy     = (state_q != S_IDLE);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign valid    = valid_q;

endmodule
